// File: rtl/legv8_pkg.sv
// LEGv8 MEM-stage shared types: widths, data-memory FSM states
// and the MEM/WB pipeline bundle.
package legv8_pkg;

    localparam int WORD    = 64;
    localparam int RD_W    = 5;
    localparam int TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            reg_write;
        logic            mem_to_reg;
        logic [WORD-1:0] alu;
        logic [WORD-1:0] rdata;
        logic            misalign;
        logic            bus_err;
    } mem_wb_t;

endpackage

// File: rtl/dmem_if_fsm.sv
// Data-memory port sequencer: REQ/WAIT FSM with a bounded
// timeout; reports a one-cycle completion (done, err on timeout).
module dmem_if_fsm
    import legv8_pkg::*;
#(
    parameter int LIMIT = TIMEOUT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            store,
    input  logic [WORD-1:0] addr,
    input  logic [WORD-1:0] wdata,
    input  logic            dm_gnt,
    input  logic            dm_rvalid,
    output logic            busy,
    output logic            dm_req,
    output logic            dm_we,
    output logic [WORD-1:0] dm_addr,
    output logic [WORD-1:0] dm_wdata,
    output logic            done,
    output logic            err
);

    localparam int CW = $clog2(LIMIT + 1);

    mem_state_t      state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [WORD-1:0] addr_q, wdata_q;
    logic            we_q;
    logic            timed_out;

    assign timed_out = (cnt_q == CW'(LIMIT - 1));
    assign busy      = (state_q != IDLE);
    assign dm_req    = (state_q == REQ);
    assign dm_we     = dm_req & we_q;
    assign dm_addr   = dm_req ? addr_q : '0;
    assign dm_wdata  = dm_req ? wdata_q : '0;

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        err     = 1'b0;
        unique case (state_q)
            IDLE: if (start) state_d = REQ;
            REQ: begin
                if (dm_gnt && (we_q || dm_rvalid)) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (timed_out) begin
                    done    = 1'b1;
                    err     = 1'b1;
                    state_d = IDLE;
                end else if (dm_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (dm_rvalid) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (timed_out) begin
                    done    = 1'b1;
                    err     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                cnt_q   <= '0;
                addr_q  <= addr;
                wdata_q <= wdata;
                we_q    <= store;
            end else if (busy) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// LEGv8 MEM stage: EX handshake, branch resolution, load/store
// via dmem_if_fsm, and the registered MEM/WB bundle.
module mem_stage
    import legv8_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    output logic            mem_ready,
    input  logic [WORD-1:0] alu_out,
    input  logic [WORD-1:0] br_addr,
    input  logic            z_flag,
    input  logic [WORD-1:0] st_data,
    input  logic [RD_W-1:0] rd,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            branch,
    input  logic            cbnz,
    input  logic            uncond,
    input  logic            reg_write,
    input  logic            mem_to_reg,
    output logic            dm_req,
    output logic            dm_we,
    output logic [WORD-1:0] dm_addr,
    output logic [WORD-1:0] dm_wdata,
    input  logic            dm_gnt,
    input  logic            dm_rvalid,
    input  logic [WORD-1:0] dm_rdata,
    output logic            pc_src,
    output logic [WORD-1:0] br_target,
    output logic            wb_valid,
    output logic [RD_W-1:0] wb_rd,
    output logic            wb_reg_write,
    output logic            wb_mem_to_reg,
    output logic [WORD-1:0] wb_alu,
    output logic [WORD-1:0] wb_rdata,
    output logic            misalign,
    output logic            bus_err
);

    logic            accept, is_mem, mis, start, busy, done, err, taken;
    logic [RD_W-1:0] pend_rd;
    logic            pend_rw, pend_m2r, pend_load;
    logic [WORD-1:0] pend_alu;
    mem_wb_t         wb_q;

    assign mem_ready = ~busy;
    assign accept    = ex_valid & mem_ready;
    assign is_mem    = mem_read | mem_write;
    assign mis       = is_mem & (alu_out[2:0] != 3'b000);
    assign start     = accept & is_mem & ~mis;
    assign taken     = uncond | (branch & (cbnz ? ~z_flag : z_flag));

    dmem_if_fsm #(.LIMIT(TIMEOUT)) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .store     (mem_write),
        .addr      (alu_out),
        .wdata     (st_data),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .busy      (busy),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .done      (done),
        .err       (err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q      <= '0;
            pc_src    <= 1'b0;
            br_target <= '0;
            pend_rd   <= '0;
            pend_rw   <= 1'b0;
            pend_m2r  <= 1'b0;
            pend_load <= 1'b0;
            pend_alu  <= '0;
        end else begin
            wb_q.valid    <= 1'b0;
            wb_q.misalign <= 1'b0;
            wb_q.bus_err  <= 1'b0;
            pc_src        <= 1'b0;
            if (accept && !is_mem) begin
                wb_q.valid      <= 1'b1;
                wb_q.rd         <= rd;
                wb_q.reg_write  <= reg_write;
                wb_q.mem_to_reg <= mem_to_reg;
                wb_q.alu        <= alu_out;
                wb_q.rdata      <= '0;
                pc_src          <= taken;
                br_target       <= br_addr;
            end else if (accept && mis) begin
                wb_q.valid      <= 1'b1;
                wb_q.misalign   <= 1'b1;
                wb_q.rd         <= rd;
                wb_q.reg_write  <= 1'b0;
                wb_q.mem_to_reg <= mem_to_reg;
                wb_q.alu        <= alu_out;
                wb_q.rdata      <= '0;
            end else if (start) begin
                pend_rd   <= rd;
                pend_rw   <= reg_write;
                pend_m2r  <= mem_to_reg;
                pend_alu  <= alu_out;
                pend_load <= ~mem_write;
            end
            // done never coincides with accept: the FSM is busy then
            if (done) begin
                wb_q.valid      <= 1'b1;
                wb_q.bus_err    <= err;
                wb_q.rd         <= pend_rd;
                wb_q.reg_write  <= pend_rw & ~err;
                wb_q.mem_to_reg <= pend_m2r;
                wb_q.alu        <= pend_alu;
                wb_q.rdata      <= (pend_load && !err) ? dm_rdata : '0;
            end
        end
    end

    assign wb_valid      = wb_q.valid;
    assign wb_rd         = wb_q.rd;
    assign wb_reg_write  = wb_q.reg_write;
    assign wb_mem_to_reg = wb_q.mem_to_reg;
    assign wb_alu        = wb_q.alu;
    assign wb_rdata      = wb_q.rdata;
    assign misalign      = wb_q.misalign;
    assign bus_err       = wb_q.bus_err;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-cycle ops plus
// load/store, timeout and reset sequences.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        mem_ready;
    logic [63:0] alu_out, br_addr, st_data;
    logic        z_flag;
    logic [4:0]  rd;
    logic        mem_read, mem_write, branch, cbnz, uncond;
    logic        reg_write, mem_to_reg;
    logic        dm_req, dm_we;
    logic [63:0] dm_addr, dm_wdata;
    logic        dm_gnt, dm_rvalid;
    logic [63:0] dm_rdata;
    logic        pc_src;
    logic [63:0] br_target;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_reg_write, wb_mem_to_reg;
    logic [63:0] wb_alu, wb_rdata;
    logic        misalign, bus_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .mem_ready     (mem_ready),
        .alu_out       (alu_out),
        .br_addr       (br_addr),
        .z_flag        (z_flag),
        .st_data       (st_data),
        .rd            (rd),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .branch        (branch),
        .cbnz          (cbnz),
        .uncond        (uncond),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .dm_req        (dm_req),
        .dm_we         (dm_we),
        .dm_addr       (dm_addr),
        .dm_wdata      (dm_wdata),
        .dm_gnt        (dm_gnt),
        .dm_rvalid     (dm_rvalid),
        .dm_rdata      (dm_rdata),
        .pc_src        (pc_src),
        .br_target     (br_target),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_alu        (wb_alu),
        .wb_rdata      (wb_rdata),
        .misalign      (misalign),
        .bus_err       (bus_err)
    );

    typedef struct {
        logic [63:0] alu;
        logic [63:0] br;
        logic        z;
        logic        brf;
        logic        cbnz;
        logic        unc;
        logic        mrd;
        logic        mwr;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
        logic        e_pc;
        logic        e_rw;
        logic        e_mis;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ex_valid   = 1'b0;
        alu_out    = '0;
        br_addr    = '0;
        st_data    = '0;
        z_flag     = 1'b0;
        rd         = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        cbnz       = 1'b0;
        uncond     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
    endtask

    task automatic issue_mem(input logic [63:0] a, input logic ld,
                             input logic st, input logic [63:0] d,
                             input logic [4:0] r);
        idle_inputs();
        ex_valid   = 1'b1;
        alu_out    = a;
        mem_read   = ld;
        mem_write  = st;
        st_data    = d;
        rd         = r;
        reg_write  = ld & ~st;
        mem_to_reg = ld & ~st;
    endtask

    initial begin
        logic ready_low;
        vecs[0] = '{64'd28, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    5'd10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{64'd0, 64'd180, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                    5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{64'd0, 64'd200, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                    5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{64'd0, 64'd204, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                    5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{64'd0, 64'd208, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                    5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{64'd0, 64'd456, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                    5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{64'd86, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                    5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{64'd124, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                    5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        idle_inputs();
        dm_gnt    = 1'b0;
        dm_rvalid = 1'b0;
        dm_rdata  = '0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mem_ready", mem_ready, 1);
        chk("rst_dm_req", dm_req, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_pc_src", pc_src, 0);
        chk("rst_br_target", br_target, 0);
        chk("rst_wb_alu", wb_alu, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            ex_valid  = 1'b1;
            alu_out   = vecs[i].alu;
            br_addr   = vecs[i].br;
            z_flag    = vecs[i].z;
            branch    = vecs[i].brf;
            cbnz      = vecs[i].cbnz;
            uncond    = vecs[i].unc;
            mem_read  = vecs[i].mrd;
            mem_write = vecs[i].mwr;
            rd        = vecs[i].rd;
            reg_write = vecs[i].rw;
            mem_to_reg = vecs[i].m2r;
            @(negedge clk);
            idle_inputs();
            chk($sformatf("v%0d_wb_valid", i), wb_valid, 1);
            chk($sformatf("v%0d_pc_src", i), pc_src, vecs[i].e_pc);
            chk($sformatf("v%0d_misalign", i), misalign, vecs[i].e_mis);
            chk($sformatf("v%0d_wb_rw", i), wb_reg_write, vecs[i].e_rw);
            chk($sformatf("v%0d_wb_alu", i), wb_alu, vecs[i].alu);
            chk($sformatf("v%0d_wb_rd", i), wb_rd, vecs[i].rd);
            chk($sformatf("v%0d_dm_req", i), dm_req, 0);
            chk($sformatf("v%0d_ready", i), mem_ready, 1);
            if (vecs[i].e_pc)
                chk($sformatf("v%0d_br_target", i), br_target, vecs[i].br);
            @(negedge clk);
            chk($sformatf("v%0d_wb_pulse", i), wb_valid, 0);
            chk($sformatf("v%0d_pc_pulse", i), pc_src, 0);
        end

        // LDUR 88: gnt on 2nd REQ cycle, rvalid on 3rd WAIT cycle
        issue_mem(64'd88, 1'b1, 1'b0, 64'd0, 5'd3);
        @(negedge clk);
        idle_inputs();
        ready_low = 1'b1;
        chk("ld_req1", dm_req, 1);
        chk("ld_addr", dm_addr, 88);
        chk("ld_we", dm_we, 0);
        ready_low &= ~mem_ready;
        @(negedge clk);
        chk("ld_req2", dm_req, 1);
        chk("ld_addr2", dm_addr, 88);
        ready_low &= ~mem_ready;
        dm_gnt = 1'b1;
        @(negedge clk);
        dm_gnt = 1'b0;
        chk("ld_wait_req", dm_req, 0);
        ready_low &= ~mem_ready;
        @(negedge clk);
        ready_low &= ~mem_ready;
        chk("ld_wait_wb", wb_valid, 0);
        @(negedge clk);
        ready_low &= ~mem_ready;
        dm_rvalid = 1'b1;
        dm_rdata  = 64'hDEAD;
        @(negedge clk);
        dm_rvalid = 1'b0;
        dm_rdata  = '0;
        chk("ld_ready_low", ready_low, 1);
        chk("ld_wb_valid", wb_valid, 1);
        chk("ld_rdata", wb_rdata, 64'hDEAD);
        chk("ld_rd", wb_rd, 3);
        chk("ld_rw", wb_reg_write, 1);
        chk("ld_m2r", wb_mem_to_reg, 1);
        chk("ld_bus_err", bus_err, 0);
        chk("ld_ready_back", mem_ready, 1);

        // STUR 120, immediate grant
        issue_mem(64'd120, 1'b0, 1'b1, 64'h5A, 5'd0);
        @(negedge clk);
        idle_inputs();
        dm_gnt = 1'b1;
        chk("st_req", dm_req, 1);
        chk("st_we", dm_we, 1);
        chk("st_wdata", dm_wdata, 64'h5A);
        chk("st_addr", dm_addr, 120);
        chk("st_wb_early", wb_valid, 0);
        @(negedge clk);
        dm_gnt = 1'b0;
        chk("st_wb_valid", wb_valid, 1);
        chk("st_rw", wb_reg_write, 0);
        chk("st_ready", mem_ready, 1);
        chk("st_req_off", dm_req, 0);

        // both read and write: store wins
        issue_mem(64'd16, 1'b1, 1'b1, 64'h77, 5'd4);
        @(negedge clk);
        idle_inputs();
        dm_gnt = 1'b1;
        chk("rw_we", dm_we, 1);
        chk("rw_wdata", dm_wdata, 64'h77);
        @(negedge clk);
        dm_gnt = 1'b0;
        chk("rw_wb_valid", wb_valid, 1);

        // load never granted: bus error after 16 busy cycles
        issue_mem(64'd64, 1'b1, 1'b0, 64'd0, 5'd9);
        @(negedge clk);
        idle_inputs();
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
        end
        chk("to_last_req", dm_req, 1);
        chk("to_no_wb", wb_valid, 0);
        @(negedge clk);
        chk("to_wb_valid", wb_valid, 1);
        chk("to_bus_err", bus_err, 1);
        chk("to_rw", wb_reg_write, 0);
        chk("to_req_off", dm_req, 0);
        chk("to_ready", mem_ready, 1);
        @(negedge clk);
        chk("to_err_pulse", bus_err, 0);

        // reset while waiting for rvalid
        issue_mem(64'd96, 1'b1, 1'b0, 64'd0, 5'd2);
        @(negedge clk);
        idle_inputs();
        dm_gnt = 1'b1;
        @(negedge clk);
        dm_gnt = 1'b0;
        chk("rw_in_wait", dm_req, 0);
        chk("rw_busy", mem_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rw_ready", mem_ready, 1);
        chk("rw_req", dm_req, 0);
        chk("rw_wb", wb_valid, 0);
        dm_rvalid = 1'b1;
        dm_gnt    = 1'b1;
        dm_rdata  = 64'hBEEF;
        @(negedge clk);
        dm_rvalid = 1'b0;
        dm_gnt    = 1'b0;
        chk("stray_rvalid", wb_valid, 0);
        chk("stray_req", dm_req, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
